// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage integer pipeline.
// Ports: clk, rst (async, active-high); ID decode fields (id_valid,
//   id_reg{1,2}_read/addr, id_reg_write, id_write_addr, id_DM_read,
//   id_DM_write); ex_branch_taken; dm_ack.  Outputs: pc_stall,
//   if_id_stall, id_ex_bubble, if_id_flush, mem_stall,
//   id_fwd{1,2}_sel, dm_req, dm_err (sticky timeout).
module hazard_ctrl #(
   parameter int DM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic       id_reg1_read,
   input  logic       id_reg2_read,
   input  logic [4:0] id_reg1_addr,
   input  logic [4:0] id_reg2_addr,
   input  logic       id_reg_write,
   input  logic [4:0] id_write_addr,
   input  logic       id_DM_read,
   input  logic       id_DM_write,
   input  logic       ex_branch_taken,
   input  logic       dm_ack,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       id_ex_bubble,
   output logic       if_id_flush,
   output logic       mem_stall,
   output logic [1:0] id_fwd1_sel,
   output logic [1:0] id_fwd2_sel,
   output logic       dm_req,
   output logic       dm_err
);

   typedef struct packed {
      logic       valid;
      logic       wr;
      logic [4:0] addr;
      logic       load;
      logic       mem;
   } tag_t;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   // Last WAIT cycle before the access is abandoned.
   localparam logic [7:0] TMO_LAST = 8'(DM_TIMEOUT - 1);

   tag_t       ex_tag;
   tag_t       mem_tag;
   tag_t       wb_tag;
   tag_t       id_tag;
   state_t     state;
   logic [7:0] cnt;

   logic req_c;
   logic tmo_c;
   logic stall_c;
   logic flush_c;
   logic hit1_c;
   logic hit2_c;
   logic lu_c;
   logic bubble_c;

   // Nearest producer wins; a load in EX has no data yet.
   function automatic logic [1:0] fwd_sel(
      input logic       rd,
      input logic [4:0] a,
      input tag_t       ex,
      input tag_t       mem,
      input tag_t       wb
   );
      logic [1:0] s;
      s = 2'b00;
      if (rd) begin
         if (ex.valid && ex.wr && ex.addr == a && !ex.load)
            s = 2'b01;
         else if (mem.valid && mem.wr && mem.addr == a)
            s = 2'b10;
         else if (wb.valid && wb.wr && wb.addr == a)
            s = 2'b11;
      end
      return s;
   endfunction

   assign req_c = (state == ST_WAIT)
                | (mem_tag.valid & mem_tag.mem);

   // A real ack in the last cycle wins over the timeout.
   assign tmo_c = (state == ST_WAIT)
                & (cnt == TMO_LAST) & !dm_ack;

   assign stall_c = req_c & !dm_ack & !tmo_c;

   assign flush_c = ex_branch_taken & !stall_c;

   assign hit1_c = id_reg1_read
                 & (id_reg1_addr == ex_tag.addr);
   assign hit2_c = id_reg2_read
                 & (id_reg2_addr == ex_tag.addr);

   assign lu_c = id_valid & ex_tag.valid & ex_tag.load
               & (hit1_c | hit2_c)
               & !stall_c & !flush_c;

   assign bubble_c = !stall_c & (flush_c | lu_c);

   assign id_tag = '{
      valid: id_valid & !bubble_c,
      wr:    id_reg_write,
      addr:  id_write_addr,
      load:  id_DM_read,
      mem:   id_DM_read | id_DM_write
   };

   // Outputs are forced quiet while reset is held.
   assign pc_stall     = !rst & (stall_c | lu_c);
   assign if_id_stall  = !rst & (stall_c | lu_c);
   assign id_ex_bubble = !rst & bubble_c;
   assign if_id_flush  = !rst & flush_c;
   assign mem_stall    = !rst & stall_c;
   assign dm_req       = !rst & req_c;

   assign id_fwd1_sel = rst ? 2'b00 :
      fwd_sel(id_reg1_read, id_reg1_addr,
              ex_tag, mem_tag, wb_tag);
   assign id_fwd2_sel = rst ? 2'b00 :
      fwd_sel(id_reg2_read, id_reg2_addr,
              ex_tag, mem_tag, wb_tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_tag  <= '0;
         mem_tag <= '0;
         wb_tag  <= '0;
      end else if (!stall_c) begin
         ex_tag  <= id_tag;
         mem_tag <= ex_tag;
         wb_tag  <= mem_tag;
         // A timed-out access never writes back.
         if (tmo_c)
            wb_tag.wr <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= 8'd0;
         dm_err <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               cnt <= 8'd0;
               if (req_c && !dm_ack)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (dm_ack) begin
                  state <= ST_IDLE;
               end else if (tmo_c) begin
                  state  <= ST_IDLE;
                  dm_err <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (DM_TIMEOUT = 4).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic       r1_rd;
   logic       r2_rd;
   logic [4:0] r1_a;
   logic [4:0] r2_a;
   logic       wr;
   logic [4:0] wa;
   logic       ld;
   logic       st;
   logic       br;
   logic       ack;
   logic       pc_stall;
   logic       if_id_stall;
   logic       id_ex_bubble;
   logic       if_id_flush;
   logic       mem_stall;
   logic [1:0] f1;
   logic [1:0] f2;
   logic       dm_req;
   logic       dm_err;
   logic [10:0] outs;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.DM_TIMEOUT(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_reg1_read    (r1_rd),
      .id_reg2_read    (r2_rd),
      .id_reg1_addr    (r1_a),
      .id_reg2_addr    (r2_a),
      .id_reg_write    (wr),
      .id_write_addr   (wa),
      .id_DM_read      (ld),
      .id_DM_write     (st),
      .ex_branch_taken (br),
      .dm_ack          (ack),
      .pc_stall        (pc_stall),
      .if_id_stall     (if_id_stall),
      .id_ex_bubble    (id_ex_bubble),
      .if_id_flush     (if_id_flush),
      .mem_stall       (mem_stall),
      .id_fwd1_sel     (f1),
      .id_fwd2_sel     (f2),
      .dm_req          (dm_req),
      .dm_err          (dm_err)
   );

   assign outs = {pc_stall, if_id_stall, id_ex_bubble,
                  if_id_flush, mem_stall, f1, f2,
                  dm_req, dm_err};

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic id_set(input logic v,
                         input logic rd1,
                         input logic [4:0] a1,
                         input logic rd2,
                         input logic [4:0] a2,
                         input logic w,
                         input logic [4:0] d,
                         input logic l,
                         input logic s);
      id_valid = v;
      r1_rd = rd1;
      r1_a  = a1;
      r2_rd = rd2;
      r2_a  = a2;
      wr    = w;
      wa    = d;
      ld    = l;
      st    = s;
   endtask

   task automatic nop();
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      br  = 1'b0;
      ack = 1'b0;
      nop();
      #1 check("rst_outs", 32'(outs), 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("idle_outs", 32'(outs), 0);

      // ADD r3,r1,r2 ; ADD r4,r3,r5 ; ADD r8 ; NOP ; use r8,r4
      id_set(1, 1, 1, 1, 2, 1, 3, 0, 0);
      #1 check("fwd_none", 32'({f1, f2}), 0);
      step();
      id_set(1, 1, 3, 1, 5, 1, 4, 0, 0);
      #1 check("fwd_ex1", 32'(f1), 1);
      check("fwd_ex2", 32'(f2), 0);
      step();
      id_set(1, 1, 1, 1, 2, 1, 8, 0, 0);
      step();
      nop();
      step();
      id_set(1, 1, 8, 1, 4, 0, 0, 0, 0);
      #1 check("fwd_mem", 32'(f1), 2);
      check("fwd_wb", 32'(f2), 3);
      step();

      // Two writers of r9: EX beats MEM
      id_set(1, 0, 0, 0, 0, 1, 9, 0, 0);
      step();
      step();
      id_set(1, 1, 9, 1, 9, 0, 0, 0, 0);
      #1 check("fwd_near", 32'({f1, f2}), 4'b0101);
      step();

      // r0 is an ordinary destination
      id_set(1, 0, 0, 0, 0, 1, 0, 0, 0);
      step();
      id_set(1, 0, 0, 1, 0, 0, 0, 0, 0);
      #1 check("fwd_rd_off", 32'(f1), 0);
      check("fwd_r0", 32'(f2), 1);
      step();
      nop();
      step();
      step();
      step();

      // LWI r6 ; ADD r7,r6,r2 -> one stall cycle
      id_set(1, 1, 1, 0, 0, 1, 6, 1, 0);
      step();
      id_set(1, 1, 6, 1, 2, 1, 7, 0, 0);
      #1 check("lu_stall",
               32'({pc_stall, if_id_stall,
                    id_ex_bubble, if_id_flush}), 4'b1110);
      step();
      ack = 1'b1;
      #1 check("lu_release",
               32'({pc_stall, if_id_stall, id_ex_bubble,
                    if_id_flush, mem_stall}), 0);
      check("lu_fwd", 32'(f1), 2);
      check("lu_req", 32'(dm_req), 1);
      step();
      ack = 1'b0;
      nop();
      step();
      step();
      step();

      // Taken branch overrides a load-use stall
      id_set(1, 1, 1, 0, 0, 1, 6, 1, 0);
      step();
      id_set(1, 1, 6, 0, 0, 1, 7, 0, 0);
      br = 1'b1;
      #1 check("br_ctl",
               32'({pc_stall, if_id_stall,
                    id_ex_bubble, if_id_flush}), 4'b0011);
      step();
      br  = 1'b0;
      ack = 1'b1;
      #1 check("br_after",
               32'({pc_stall, if_id_stall,
                    id_ex_bubble, if_id_flush}), 0);
      check("br_fwd", 32'(f1), 2);
      step();
      ack = 1'b0;
      nop();
      step();
      step();
      step();

      // SW ; ADD r3 ; use r3 -- ack on 4th request cycle
      id_set(1, 1, 1, 1, 2, 0, 0, 0, 1);
      step();
      id_set(1, 0, 0, 0, 0, 1, 3, 0, 0);
      step();
      id_set(1, 1, 3, 0, 0, 0, 0, 0, 0);
      br = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("sw_stall",
                  32'({pc_stall, if_id_stall, id_ex_bubble,
                       if_id_flush, mem_stall, dm_req}),
                  6'b110011);
         check("sw_hold_fwd", 32'(f1), 1);
         step();
      end
      br  = 1'b0;
      ack = 1'b1;
      #1 check("sw_ack",
               32'({pc_stall, if_id_stall, id_ex_bubble,
                    if_id_flush, mem_stall, dm_req}),
               6'b000001);
      step();
      ack = 1'b0;
      #1 check("sw_shift", 32'(f1), 2);
      check("sw_done", 32'({mem_stall, dm_req}), 0);
      step();
      nop();
      step();
      step();
      step();

      // LWI r10 with no ack -> timeout after 4 WAIT cycles
      id_set(1, 1, 1, 0, 0, 1, 10, 1, 0);
      step();
      nop();
      step();
      #1 check("to_req",
               32'({mem_stall, dm_req, dm_err}), 3'b110);
      step();
      for (int i = 0; i < 3; i++) begin
         #1 check("to_wait",
                  32'({mem_stall, dm_req, dm_err}), 3'b110);
         step();
      end
      #1 check("to_last",
               32'({mem_stall, dm_req, dm_err}), 3'b010);
      step();
      id_set(1, 1, 10, 0, 0, 0, 0, 0, 0);
      #1 check("to_err", 32'(dm_err), 1);
      check("to_discard", 32'(f1), 0);
      check("to_idle", 32'({mem_stall, dm_req}), 0);
      step();
      nop();
      step();
      #1 check("to_sticky", 32'(dm_err), 1);
      step();
      step();

      // Reset during WAIT with a taken branch pending
      id_set(1, 1, 1, 1, 2, 0, 0, 0, 1);
      step();
      nop();
      step();
      step();
      id_set(1, 1, 3, 0, 0, 0, 0, 0, 0);
      br = 1'b1;
      #1 check("rw_pre",
               32'({mem_stall, dm_req, dm_err}), 3'b111);
      #1 rst = 1'b1;
      #1 check("rst_async", 32'(outs), 0);
      step();
      rst = 1'b0;
      br  = 1'b0;
      id_set(1, 1, 3, 1, 4, 1, 5, 0, 0);
      #1 check("rst_clean", 32'(outs), 0);
      step();
      id_set(1, 1, 5, 0, 0, 0, 0, 0, 0);
      #1 check("rst_resume", 32'(f1), 1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
